// File: rtl/led_pwm_bank.sv
// Multi-channel LED driver: shared prescaler and phase counter, per-channel
// off/on/PWM/breathe compare with period-aligned shadowing of mode and duty.
module led_pwm_bank #(
  parameter int CHANNELS       = 4,
  parameter int CNT_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [PRESCALE_WIDTH-1:0]     prescale,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CNT_WIDTH*CHANNELS-1:0] duty,
  output logic [CHANNELS-1:0]           led,
  output logic                          tick,
  output logic                          period_start
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic [PRESCALE_WIDTH-1:0] pre_term;
  logic                      pre_hit;
  logic [CNT_WIDTH-1:0]      cnt;
  logic                      load_pending;
  logic                      wrap;
  logic                      capture;

  logic [1:0]           shadow_mode [CHANNELS];
  logic [CNT_WIDTH-1:0] shadow_duty [CHANNELS];
  logic [CNT_WIDTH-1:0] level       [CHANNELS];
  logic                 level_down  [CHANNELS];
  logic [CHANNELS-1:0]  led_next;

  function automatic logic lit(input logic [1:0]           m,
                               input logic [CNT_WIDTH-1:0] c,
                               input logic [CNT_WIDTH-1:0] d,
                               input logic [CNT_WIDTH-1:0] l);
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return c < d;
      default: return c < l;
    endcase
  endfunction

  // Returns {direction_down_next, level_next}; turns around at the extremes.
  function automatic logic [CNT_WIDTH:0] breathe_step(input logic [CNT_WIDTH-1:0] lvl,
                                                      input logic                 down);
    logic [CNT_WIDTH-1:0] nl;
    if (!down) begin
      nl = lvl + CNT_WIDTH'(1);
      return {nl == CNT_MAX, nl};
    end else begin
      nl = lvl - CNT_WIDTH'(1);
      return {nl != '0, nl};
    end
  endfunction

  // A prescale of 0 behaves as 1; >= lets a lowered divide value tick at once.
  assign pre_term = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
  assign pre_hit  = pre_cnt >= pre_term;
  assign wrap     = tick && (cnt == CNT_MAX);
  assign capture  = load_pending || wrap;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      pre_cnt      <= '0;
      cnt          <= '0;
      tick         <= 1'b0;
      period_start <= 1'b0;
      load_pending <= 1'b1;
    end else begin
      if (pre_hit) begin
        pre_cnt <= '0;
        tick    <= 1'b1;
      end else begin
        pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
        tick    <= 1'b0;
      end
      if (tick) cnt <= cnt + CNT_WIDTH'(1);
      period_start <= wrap;
      load_pending <= 1'b0;
    end
  end

  // On the first enabled edge the shadows are being loaded, so compare against
  // the incoming settings rather than stale ones.
  always_comb begin
    led_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load_pending)
        led_next[i] = lit(mode[2*i +: 2], cnt, duty[CNT_WIDTH*i +: CNT_WIDTH], level[i]);
      else
        led_next[i] = lit(shadow_mode[i], cnt, shadow_duty[i], level[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_mode[i] <= 2'b00;
        shadow_duty[i] <= '0;
        level[i]       <= '0;
        level_down[i]  <= 1'b0;
      end
    end else if (!enable) begin
      led <= '0;
    end else begin
      led <= led_next;
      for (int i = 0; i < CHANNELS; i++) begin
        if (capture) begin
          shadow_mode[i] <= mode[2*i +: 2];
          shadow_duty[i] <= duty[CNT_WIDTH*i +: CNT_WIDTH];
        end
        // The breathe step follows the mode being captured on this wrap.
        if (wrap && (mode[2*i +: 2] == 2'b11))
          {level_down[i], level[i]} <= breathe_step(level[i], level_down[i]);
      end
    end
  end

endmodule
